// File: rtl/serial_addsub_if.sv
// serial_addsub_if: start/busy/done handshake plus operand and result bus
// for the digit-serial adder/subtractor.
interface serial_addsub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;

    modport master (
        output start,
        output sub,
        output a_in,
        output b_in,
        input  busy,
        input  done,
        input  result,
        input  cout,
        input  ovf
    );

    modport slave (
        input  start,
        input  sub,
        input  a_in,
        input  b_in,
        output busy,
        output done,
        output result,
        output cout,
        output ovf
    );
endinterface

// File: rtl/serial_addsub.sv
// serial_addsub: digit-serial adder/subtractor, DIGIT bits per clock,
// registered carry, result shifted in from the MSB end.
module serial_addsub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic           clk,
    input  logic           rst,
    serial_addsub_if.slave bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state;
    state_t state_nx;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_q;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             cout_q;
    logic             ovf_q;
    logic             done_q;

    logic             load;
    logic             step;
    logic             last;

    logic [DIGIT-1:0]       a_dig;
    logic [DIGIT-1:0]       b_dig;
    logic [DIGIT-1:0]       s_dig;
    logic [DIGIT:0]         dsum;
    logic [WIDTH+DIGIT-1:0] res_cat;

    // One digit slice: low digits of A and B plus the registered carry.
    always_comb begin
        a_dig   = a_sh[DIGIT-1:0];
        b_dig   = b_sh[DIGIT-1:0];
        dsum    = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry};
        s_dig   = dsum[DIGIT-1:0];
        res_cat = {s_dig, res_q};
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: accept start only in IDLE, run N steps.
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        step     = 1'b0;
        last     = (cnt == LAST);
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load     = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Datapath: operand load, digit shifting and final flag capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_q  <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (load) begin
                a_sh   <= bus.a_in;
                b_sh   <= bus.sub ? ~bus.b_in : bus.b_in;
                carry  <= bus.sub;
                cnt    <= '0;
                res_q  <= '0;
                cout_q <= 1'b0;
                ovf_q  <= 1'b0;
            end else if (step) begin
                a_sh  <= a_sh >> DIGIT;
                b_sh  <= b_sh >> DIGIT;
                res_q <= res_cat[WIDTH+DIGIT-1:DIGIT];
                carry <= dsum[DIGIT];
                cnt   <= cnt + CW'(1);
                if (last) begin
                    cout_q <= dsum[DIGIT];
                    ovf_q  <= (a_dig[DIGIT-1] == b_dig[DIGIT-1])
                           && (s_dig[DIGIT-1] != a_dig[DIGIT-1]);
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign bus.busy   = (state == RUN);
    assign bus.done   = done_q;
    assign bus.result = res_q;
    assign bus.cout   = cout_q;
    assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: three configurations (8/1, 8/4, 16/2) checked against
// an arithmetic reference model, plus handshake and reset scenarios.
module tb_serial_addsub;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    serial_addsub_if #(.WIDTH(8))  if0 ();
    serial_addsub_if #(.WIDTH(8))  if1 ();
    serial_addsub_if #(.WIDTH(16)) if2 ();

    serial_addsub #(.WIDTH(8), .DIGIT(1)) dut0 (
        .clk(clk), .rst(rst), .bus(if0)
    );
    serial_addsub #(.WIDTH(8), .DIGIT(4)) dut1 (
        .clk(clk), .rst(rst), .bus(if1)
    );
    serial_addsub #(.WIDTH(16), .DIGIT(2)) dut2 (
        .clk(clk), .rst(rst), .bus(if2)
    );

    function automatic int cfg_w(input int cfg);
        return (cfg == 2) ? 16 : 8;
    endfunction

    function automatic int cfg_n(input int cfg);
        return (cfg == 0) ? 8 : ((cfg == 1) ? 2 : 8);
    endfunction

    task automatic set_in(input int cfg, input logic st, input logic sb,
                          input logic [15:0] a, input logic [15:0] b);
        case (cfg)
            0: begin
                if0.start = st; if0.sub = sb;
                if0.a_in = a[7:0]; if0.b_in = b[7:0];
            end
            1: begin
                if1.start = st; if1.sub = sb;
                if1.a_in = a[7:0]; if1.b_in = b[7:0];
            end
            default: begin
                if2.start = st; if2.sub = sb;
                if2.a_in = a; if2.b_in = b;
            end
        endcase
    endtask

    task automatic set_start(input int cfg, input logic st);
        case (cfg)
            0: if0.start = st;
            1: if1.start = st;
            default: if2.start = st;
        endcase
    endtask

    task automatic get_out(input int cfg, output logic bsy, output logic dn,
                           output logic [15:0] res, output logic co,
                           output logic ov);
        case (cfg)
            0: begin
                bsy = if0.busy; dn = if0.done; res = {8'h00, if0.result};
                co = if0.cout; ov = if0.ovf;
            end
            1: begin
                bsy = if1.busy; dn = if1.done; res = {8'h00, if1.result};
                co = if1.cout; ov = if1.ovf;
            end
            default: begin
                bsy = if2.busy; dn = if2.done; res = if2.result;
                co = if2.cout; ov = if2.ovf;
            end
        endcase
    endtask

    // Reference: plain integer arithmetic, unsigned carry and signed range.
    task automatic ref_model(input int w, input logic sb,
                             input logic [15:0] a, input logic [15:0] b,
                             output logic [15:0] r, output logic c,
                             output logic o);
        longint m, half, av, bv, sa, sv, t, st;
        m    = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        av   = longint'(a) & m;
        bv   = longint'(b) & m;
        sa   = (av >= half) ? av - (m + 1) : av;
        sv   = (bv >= half) ? bv - (m + 1) : bv;
        if (sb) begin
            t  = av - bv;
            c  = (av >= bv);
            st = sa - sv;
        end else begin
            t  = av + bv;
            c  = (t > m);
            st = sa + sv;
        end
        r = 16'(t & m);
        o = (st >= half) || (st < -half);
    endtask

    task automatic run_op(input int cfg, input logic sb,
                          input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] r, output logic c,
                          output logic o, output int edges,
                          output int bcyc, output logic both);
        logic bsy, dn;
        edges = 0; bcyc = 0; both = 1'b0; dn = 1'b0;
        r = '0; c = 1'b0; o = 1'b0; bsy = 1'b0;
        @(negedge clk);
        set_in(cfg, 1'b1, sb, a, b);
        while (!dn && edges < 64) begin
            @(posedge clk);
            #1;
            edges++;
            set_start(cfg, 1'b0);
            get_out(cfg, bsy, dn, r, c, o);
            if (bsy) bcyc++;
            if (bsy && dn) both = 1'b1;
        end
    endtask

    task automatic test_reset();
        logic bsy, dn, co, ov;
        logic [15:0] r;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) set_in(k, 1'b0, 1'b0, 16'h0, 16'h0);
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            get_out(k, bsy, dn, r, co, ov);
            checks++;
            if ({bsy, dn, co, ov} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_flags cfg%0d: got %b exp 0000", k,
                         {bsy, dn, co, ov});
            end
            checks++;
            if (r !== 16'h0) begin
                errors++;
                $display("FAIL reset_result cfg%0d: got %h exp 0000", k, r);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_vectors();
        logic       sv [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0] av [5] = '{8'h01, 8'hFF, 8'h7F, 8'h03, 8'h80};
        logic [7:0] bv [5] = '{8'h02, 8'h01, 8'h01, 8'h05, 8'h01};
        logic [7:0] rv [5] = '{8'h03, 8'h00, 8'h80, 8'hFE, 8'h7F};
        logic       cv [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic       ov [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [15:0] r;
        logic c, o, both, bsy, dn;
        int edges, bcyc;
        for (int i = 0; i < 5; i++) begin
            run_op(0, sv[i], {8'h0, av[i]}, {8'h0, bv[i]},
                   r, c, o, edges, bcyc, both);
            checks++;
            if ({r[7:0], c, o} !== {rv[i], cv[i], ov[i]}) begin
                errors++;
                $display("FAIL vector%0d: got r=%h c=%b o=%b exp r=%h c=%b o=%b",
                         i, r[7:0], c, o, rv[i], cv[i], ov[i]);
            end
            checks++;
            if (edges !== 9) begin
                errors++;
                $display("FAIL vector%0d_latency: got %0d exp 9", i, edges);
            end
            checks++;
            if (bcyc !== 8 || both !== 1'b0) begin
                errors++;
                $display("FAIL vector%0d_busy: got cycles=%0d overlap=%b exp 8 0",
                         i, bcyc, both);
            end
            @(posedge clk);
            #1;
            get_out(0, bsy, dn, r, c, o);
            checks++;
            if ({dn, bsy, r[7:0]} !== {1'b0, 1'b0, rv[i]}) begin
                errors++;
                $display("FAIL vector%0d_hold: got dn=%b bsy=%b r=%h exp 0 0 %h",
                         i, dn, bsy, r[7:0], rv[i]);
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [15:0] r;
        logic c, o, bsy, dn;
        int edges;
        edges = 0; dn = 1'b0; r = '0; c = 1'b0; o = 1'b0;
        @(negedge clk);
        set_in(0, 1'b1, 1'b0, 16'h12, 16'h34);
        while (!dn && edges < 64) begin
            @(posedge clk);
            #1;
            edges++;
            if (edges == 3) set_in(0, 1'b1, 1'b1, 16'hFF, 16'hFF);
            else set_start(0, 1'b0);
            get_out(0, bsy, dn, r, c, o);
        end
        checks++;
        if ({r[7:0], c, o} !== {8'h46, 1'b0, 1'b0} || edges !== 9) begin
            errors++;
            $display("FAIL ignore_start: got r=%h c=%b o=%b edges=%0d exp 46 0 0 9",
                     r[7:0], c, o, edges);
        end
        @(posedge clk);
        #1;
        get_out(0, bsy, dn, r, c, o);
        checks++;
        if (bsy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start_idle: got busy=%b exp 0", bsy);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a, b, r, er;
        logic s, c, o, ec, eo, bsy, dn;
        int edges;
        @(negedge clk);
        a = 16'($urandom_range(0, 255));
        b = 16'($urandom_range(0, 255));
        s = 1'($urandom_range(0, 1));
        set_in(0, 1'b1, s, a, b);
        ref_model(8, s, a, b, er, ec, eo);
        for (int op = 0; op < 4; op++) begin
            edges = 0; dn = 1'b0;
            while (!dn && edges < 64) begin
                @(posedge clk);
                #1;
                edges++;
                get_out(0, bsy, dn, r, c, o);
                if (edges == 1) begin
                    checks++;
                    if (r !== 16'h0 || bsy !== 1'b1) begin
                        errors++;
                        $display("FAIL b2b_accept%0d: got r=%h busy=%b exp 00 1",
                                 op, r[7:0], bsy);
                    end
                end
            end
            checks++;
            if (edges !== 9) begin
                errors++;
                $display("FAIL b2b_period%0d: got %0d exp 9", op, edges);
            end
            checks++;
            if ({r, c, o} !== {er, ec, eo}) begin
                errors++;
                $display("FAIL b2b_result%0d: got %h %b %b exp %h %b %b",
                         op, r[7:0], c, o, er[7:0], ec, eo);
            end
            if (op < 3) begin
                a = 16'($urandom_range(0, 255));
                b = 16'($urandom_range(0, 255));
                s = 1'($urandom_range(0, 1));
                set_in(0, 1'b1, s, a, b);
                ref_model(8, s, a, b, er, ec, eo);
            end else begin
                set_start(0, 1'b0);
            end
        end
        @(posedge clk);
        #1;
        get_out(0, bsy, dn, r, c, o);
        checks++;
        if (bsy !== 1'b0 || r !== er) begin
            errors++;
            $display("FAIL b2b_drain: got busy=%b r=%h exp 0 %h", bsy, r[7:0],
                     er[7:0]);
        end
    endtask

    task automatic test_reset_abort();
        logic [15:0] r;
        logic c, o, bsy, dn, both, saw;
        int edges, bcyc;
        @(negedge clk);
        set_in(0, 1'b1, 1'b0, 16'h55, 16'h2A);
        @(posedge clk);
        #1;
        set_start(0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        get_out(0, bsy, dn, r, c, o);
        checks++;
        if ({bsy, dn, r, c, o} !== 20'h0) begin
            errors++;
            $display("FAIL abort_clear: got bsy=%b dn=%b r=%h c=%b o=%b exp all 0",
                     bsy, dn, r[7:0], c, o);
        end
        rst = 1'b0;
        saw = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            get_out(0, bsy, dn, r, c, o);
            if (dn || bsy) saw = 1'b1;
        end
        checks++;
        if (saw !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done: got activity=%b exp 0", saw);
        end
        run_op(0, 1'b0, 16'h55, 16'h2A, r, c, o, edges, bcyc, both);
        checks++;
        if ({r[7:0], c, o} !== {8'h7F, 1'b0, 1'b0} || edges !== 9) begin
            errors++;
            $display("FAIL abort_rerun: got r=%h c=%b o=%b edges=%0d exp 7f 0 0 9",
                     r[7:0], c, o, edges);
        end
    endtask

    task automatic test_params();
        logic [15:0] r;
        logic c, o, both;
        int edges, bcyc;
        run_op(1, 1'b0, 16'h9C, 16'h67, r, c, o, edges, bcyc, both);
        checks++;
        if ({r[7:0], c, o} !== {8'h03, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL w8d4_result: got r=%h c=%b o=%b exp 03 1 0",
                     r[7:0], c, o);
        end
        checks++;
        if (edges !== 3 || bcyc !== 2 || both !== 1'b0) begin
            errors++;
            $display("FAIL w8d4_timing: got edges=%0d busy=%0d ov=%b exp 3 2 0",
                     edges, bcyc, both);
        end
        run_op(2, 1'b1, 16'h0000, 16'h0001, r, c, o, edges, bcyc, both);
        checks++;
        if ({r, c, o} !== {16'hFFFF, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL w16d2_result: got r=%h c=%b o=%b exp ffff 0 0",
                     r, c, o);
        end
        checks++;
        if (edges !== 9 || bcyc !== 8 || both !== 1'b0) begin
            errors++;
            $display("FAIL w16d2_timing: got edges=%0d busy=%0d ov=%b exp 9 8 0",
                     edges, bcyc, both);
        end
    endtask

    task automatic test_random();
        logic [15:0] a, b, r, er;
        logic s, c, o, ec, eo, both;
        int edges, bcyc, w;
        for (int k = 0; k < 3; k++) begin
            w = cfg_w(k);
            for (int i = 0; i < 1000; i++) begin
                a = 16'($urandom) & 16'((32'h1 << w) - 1);
                b = 16'($urandom) & 16'((32'h1 << w) - 1);
                s = 1'($urandom_range(0, 1));
                ref_model(w, s, a, b, er, ec, eo);
                run_op(k, s, a, b, r, c, o, edges, bcyc, both);
                checks++;
                if ({r, c, o} !== {er, ec, eo}) begin
                    errors++;
                    $display("FAIL rand cfg%0d %h%s%h: got %h %b %b exp %h %b %b",
                             k, a, s ? "-" : "+", b, r, c, o, er, ec, eo);
                end
                checks++;
                if (edges !== cfg_n(k) + 1 || both !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_timing cfg%0d: got edges=%0d ov=%b exp %0d 0",
                             k, edges, both, cfg_n(k) + 1);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        test_params();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_addsub.md
# serial_addsub

Parametrised digit-serial adder/subtractor for the arithmetic lab datapath, successor to the fixed 8-bit bit-serial adder. It accepts two WIDTH-bit operands on a start pulse and processes DIGIT bits per clock through a DIGIT-bit adder slice with a registered carry. On completion it presents the WIDTH-bit result, carry-out and signed-overflow flags, and issues a one-cycle done pulse. The start/busy/done handshake lets a controller sequence back-to-back operations.

## Interface
- WIDTH, 8, operand/result width in bits; must be ≥ 2 and a multiple of DIGIT
- DIGIT, 1, bits processed per clock; 1 ≤ DIGIT ≤ WIDTH
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request; sampled only in IDLE
- sub  in  1  0 = a_in + b_in, 1 = a_in − b_in; sampled with start
- a_in  in  WIDTH  operand A; sampled with start
- b_in  in  WIDTH  operand B; sampled with start
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse when result/cout/ovf become final
- result  out  WIDTH  sum/difference, registered
- cout  out  1  final carry out (subtract: 1 = no borrow)
- ovf  out  1  two's-complement overflow

## Operation
- States are IDLE and RUN. N = WIDTH/DIGIT digit steps per operation.
- Reset: state = IDLE. busy, done, result, cout, ovf, the internal shift registers, carry and counter are all 0.
- IDLE with start=1:
  - Load A = a_in and B = (sub ? ~b_in : b_in).
  - Set carry = sub, counter = 0, result = 0, cout = 0, ovf = 0.
  - Go to RUN; busy = 1.
- RUN step, one per clock:
  - {c, s} = A[DIGIT-1:0] + B[DIGIT-1:0] + carry, computed at DIGIT+1 bits.
  - A and B shift right by DIGIT.
  - result = {s, result[WIDTH-1:DIGIT]}: the digit enters at the MSB end, so after N steps it is LSB-aligned.
  - carry = c; counter increments.
- Last step (counter = N−1):
  - cout = c.
  - ovf = (a_msb == b_msb') && (s_msb != a_msb), where a_msb and b_msb' are the MSBs of the operand digits in that step (b after inversion) and s_msb = s[DIGIT-1].
  - Go to IDLE, busy = 0, done = 1 for exactly one cycle.
- Arithmetic is modulo 2^WIDTH. cout and ovf are both always valid; the consumer chooses the unsigned or signed interpretation.
- start while busy is ignored: no reload, and sub/operand changes have no effect.
- start in the cycle done is high is accepted, because the state is already IDLE. The new operation clears result, cout and ovf on that edge.
- result, cout and ovf hold their values in IDLE until the next accepted start.
- rst mid-operation aborts immediately: reset values apply on the next edge and no done pulse is issued.

## Timing
- start sampled high at edge E0: busy = 1 after E0. Steps occur at edges E1..EN.
- After EN: busy = 0, done = 1, and result/cout/ovf are final. After EN+1: done = 0.
- Latency from start edge to done is N+1 edges. Maximum throughput is one operation per N+1 cycles when start is held high.
- done and busy are never high in the same cycle.
- WIDTH=8, DIGIT=1: done in the 9th cycle after start. WIDTH=8, DIGIT=4: done in the 3rd cycle. WIDTH=16, DIGIT=2: 9 edges.

## Test plan
- WIDTH=8, DIGIT=1, add 0x01+0x02 → done exactly 9 edges after start; result=0x03, cout=0, ovf=0; busy high for 8 cycles.
- Add 0xFF+0x01 → result=0x00, cout=1, ovf=0. Add 0x7F+0x01 → result=0x80, cout=0, ovf=1.
- Subtract 0x03−0x05 → result=0xFE, cout=0, ovf=0. Subtract 0x80−0x01 → result=0x7F, cout=1, ovf=1.
- Handshake:
  - Pulse start with new operands mid-RUN → ignored; the original result completes unchanged.
  - Hold start high continuously → back-to-back operations with done every 9 cycles; result clears on each accepted start.
- Reset: assert rst at step 4 of 0x55+0x2A → all outputs 0, no done pulse. A following start of 0x55+0x2A → result=0x7F.
- Parameters: WIDTH=8, DIGIT=4, add 0x9C+0x67 → done in 3rd cycle, result=0x03, cout=1, ovf=0. WIDTH=16, DIGIT=2, subtract 0x0000−0x0001 → result=0xFFFF, cout=0, ovf=0. A random sweep of 1000 operand pairs per configuration must match a reference model.
